// File: rtl/map_pkg.sv
// Shared types and constants for the wall-map port arbiter.
package map_pkg;

  localparam int COORD_W           = 6;
  localparam int MAP_W             = 64;
  localparam int MAP_H             = 44;
  localparam int STATUS_BAR_HEIGHT = 4;

  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic [2*COORD_W-1:0] map_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } arb_state_t;

endpackage

// File: rtl/map_port_arbiter_if.sv
// Bus bundle for map_port_arbiter: renderer, client handshake and RAM port.
// Stats outputs exist only when MAP_ARB_STATS_EN is defined.
interface map_port_arbiter_if #(
  parameter int N_CLIENTS = 3,
  parameter int COORD_W   = 6
);
  logic                         i_vga_busy;
  logic [COORD_W-1:0]           i_vga_x;
  logic [COORD_W-1:0]           i_vga_y;
  logic                         o_vga_is_wall;
  logic [N_CLIENTS-1:0]         i_req;
  logic [N_CLIENTS-1:0]         i_we;
  logic [N_CLIENTS*COORD_W-1:0] i_x;
  logic [N_CLIENTS*COORD_W-1:0] i_y;
  logic [N_CLIENTS-1:0]         i_wdata;
  logic [N_CLIENTS-1:0]         o_ack;
  logic                         o_rdata;
  logic [2*COORD_W-1:0]         o_mem_addr;
  logic                         o_mem_we;
  logic                         o_mem_wdata;
  logic                         i_mem_rdata;
`ifdef MAP_ARB_STATS_EN
  logic [15:0]                  o_abort_cnt;
  logic [15:0]                  o_max_wait;
`endif

  modport slave (
`ifdef MAP_ARB_STATS_EN
    output o_abort_cnt, output o_max_wait,
`endif
    input  i_vga_busy, i_vga_x, i_vga_y, i_req, i_we, i_x, i_y, i_wdata, i_mem_rdata,
    output o_vga_is_wall, o_ack, o_rdata, o_mem_addr, o_mem_we, o_mem_wdata
  );

  modport master (
`ifdef MAP_ARB_STATS_EN
    input  o_abort_cnt, input o_max_wait,
`endif
    output i_vga_busy, i_vga_x, i_vga_y, i_req, i_we, i_x, i_y, i_wdata, i_mem_rdata,
    input  o_vga_is_wall, o_ack, o_rdata, o_mem_addr, o_mem_we, o_mem_wdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin picker: first request at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    int k;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(i_ptr) + i) % N;
      if (!o_valid && i_req[k]) begin
        o_grant[k] = 1'b1;
        o_idx      = IDX_W'(k);
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/map_port_arbiter.sv
// Shares the wall-map RAM port between the VGA renderer (priority) and N clients.
// Optional MAP_ARB_STATS_EN adds saturating abort and max-wait counters.
module map_port_arbiter
  import map_pkg::*;
#(
  parameter int N_CLIENTS = 3,
  parameter int MAP_W     = map_pkg::MAP_W,
  parameter int MAP_H     = map_pkg::MAP_H,
  parameter int COORD_W   = map_pkg::COORD_W
) (
  input logic               clk,
  input logic               rst,
  map_port_arbiter_if.slave bus
);

  localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLIENTS - 1);

  arb_state_t           r_state;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_idx;
  logic [COORD_W-1:0]   r_x;
  logic [COORD_W-1:0]   r_y;
  logic                 r_we;
  logic                 r_wdata;
  logic                 r_oor;
  logic [N_CLIENTS-1:0] r_ack;
  logic                 r_rdata;
  logic                 r_vga_is_wall;

  logic [N_CLIENTS-1:0] w_req;
  logic [N_CLIENTS-1:0] w_grant;
  logic [IDX_W-1:0]     w_grant_idx;
  logic                 w_grant_vld;
  logic [COORD_W-1:0]   w_sel_x;
  logic [COORD_W-1:0]   w_sel_y;
  logic                 w_sel_we;
  logic                 w_sel_wdata;
  logic                 w_sel_oor;
  logic                 w_mem_we;

  // A client just acked may still hold req for one cycle; keep it out of the next pick.
  assign w_req = bus.i_req & ~r_ack;

  rr_arbiter #(
    .N     (N_CLIENTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_valid (w_grant_vld)
  );

  always_comb begin
    w_sel_x     = '0;
    w_sel_y     = '0;
    w_sel_we    = 1'b0;
    w_sel_wdata = 1'b0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      if (w_grant[k]) begin
        w_sel_x     = bus.i_x[k*COORD_W +: COORD_W];
        w_sel_y     = bus.i_y[k*COORD_W +: COORD_W];
        w_sel_we    = bus.i_we[k];
        w_sel_wdata = bus.i_wdata[k];
      end
    end
  end

  assign w_sel_oor = (int'(w_sel_y) >= MAP_H) || (int'(w_sel_x) >= MAP_W);

  assign w_mem_we        = (r_state == ISSUE) && !bus.i_vga_busy && r_we && !r_oor;
  assign bus.o_mem_we    = w_mem_we;
  assign bus.o_mem_wdata = w_mem_we & r_wdata;
  assign bus.o_mem_addr  = bus.i_vga_busy ? {bus.i_vga_y, bus.i_vga_x} : {r_y, r_x};

  assign bus.o_ack         = r_ack;
  assign bus.o_rdata       = r_rdata;
  assign bus.o_vga_is_wall = r_vga_is_wall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vga_is_wall <= 1'b0;
    end else begin
      r_vga_is_wall <= bus.i_mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_we    <= 1'b0;
      r_wdata <= 1'b0;
      r_oor   <= 1'b0;
      r_ack   <= '0;
      r_rdata <= 1'b0;
    end else begin
      r_ack <= '0;
      unique case (r_state)
        IDLE: begin
          if (!bus.i_vga_busy && w_grant_vld) begin
            r_idx   <= w_grant_idx;
            r_x     <= w_sel_x;
            r_y     <= w_sel_y;
            r_we    <= w_sel_we;
            r_wdata <= w_sel_wdata;
            r_oor   <= w_sel_oor;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          // Renderer grabbed the port: drop the op silently, client retries later.
          r_state <= bus.i_vga_busy ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          r_rdata <= r_we ? 1'b0 : (r_oor ? 1'b1 : bus.i_mem_rdata);
          r_ack   <= N_CLIENTS'(1) << r_idx;
          r_ptr   <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MAP_ARB_STATS_EN
  logic [15:0] r_abort_cnt;
  logic [15:0] r_max_wait;
  logic [15:0] r_wait [N_CLIENTS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_abort_cnt <= '0;
      r_max_wait  <= '0;
      for (int k = 0; k < N_CLIENTS; k++) r_wait[k] <= '0;
    end else begin
      if ((r_state == ISSUE) && bus.i_vga_busy && (r_abort_cnt != '1)) begin
        r_abort_cnt <= r_abort_cnt + 1'b1;
      end
      for (int k = 0; k < N_CLIENTS; k++) begin
        if (r_ack[k]) begin
          if (r_wait[k] > r_max_wait) r_max_wait <= r_wait[k];
          r_wait[k] <= '0;
        end else if (bus.i_req[k]) begin
          if (r_wait[k] != '1) r_wait[k] <= r_wait[k] + 1'b1;
        end else begin
          r_wait[k] <= '0;
        end
      end
    end
  end

  assign bus.o_abort_cnt = r_abort_cnt;
  assign bus.o_max_wait  = r_max_wait;
`endif

endmodule

// File: tb/tb_map_port_arbiter.sv
// Scoreboard bench for map_port_arbiter with a behavioural 64x64 synchronous RAM.
module tb_map_port_arbiter;

  typedef struct {
    logic [2:0] ack;
    logic       rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_wr = 0;
  int   n_ack = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  int   ack_cyc[$];

  logic        ram [4096];
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = '0;
  logic        pl_d = 1'b0;

  map_port_arbiter_if #(.N_CLIENTS(3), .COORD_W(6)) bus ();

  map_port_arbiter #(.N_CLIENTS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_d;
    else if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
    bus.i_mem_rdata <= ram[bus.o_mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_ack != '0) begin
      n_ack++;
      if (sb_q.size() == 0) begin
        check_eq("sb_extra_ack", 32'(bus.o_ack), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("sb_ack", 32'(bus.o_ack), 32'(mon_e.ack));
        check_eq("sb_rdata", 32'(bus.o_rdata), 32'(mon_e.rdata));
      end
    end
    if (bus.o_mem_we) n_wr++;
  end

  function automatic logic [11:0] a(input int x, input int y);
    logic [5:0] xx;
    logic [5:0] yy;
    xx = x[5:0];
    yy = y[5:0];
    return {yy, xx};
  endfunction

  task automatic preload(input int x, input int y, input logic d);
    @(negedge clk);
    pl_addr = a(x, y);
    pl_d    = d;
    pl_we   = 1'b1;
    @(negedge clk);
    pl_we   = 1'b0;
  endtask

  task automatic set_client(input int k, input bit we, input int x, input int y, input bit wd);
    logic [5:0] xx;
    logic [5:0] yy;
    xx = x[5:0];
    yy = y[5:0];
    bus.i_we[k]           = we;
    bus.i_wdata[k]        = wd;
    bus.i_x[k*6 +: 6]     = xx;
    bus.i_y[k*6 +: 6]     = yy;
    bus.i_req[k]          = 1'b1;
  endtask

  task automatic push_exp(input int k, input bit we, input int x, input int y);
    exp_t e;
    e.ack    = '0;
    e.ack[k] = 1'b1;
    e.rdata  = we ? 1'b0 : ((y >= 44) ? 1'b1 : ram[a(x, y)]);
    sb_q.push_back(e);
  endtask

  task automatic wait_acks(input int need, input bit hold);
    int got;
    got = 0;
    ack_cyc.delete();
    for (int n = 0; n < 60 && got < need; n++) begin
      @(negedge clk);
      if (bus.o_ack != '0) begin
        ack_cyc.push_back(cyc);
        got++;
        if (!hold) bus.i_req = bus.i_req & ~bus.o_ack;
        else if (got == need) bus.i_req = '0;
      end
    end
    if (got != need) check_eq("ack_timeout", 32'(got), 32'(need));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t0;
    int wr0;
    int ack0;
    rst            = 1'b1;
    bus.i_vga_busy = 1'b0;
    bus.i_vga_x    = '0;
    bus.i_vga_y    = '0;
    bus.i_req      = '0;
    bus.i_we       = '0;
    bus.i_wdata    = '0;
    bus.i_x        = '0;
    bus.i_y        = '0;
    for (int i = 0; i < 4096; i++) begin
      pl_addr = 12'(i);
      pl_d    = 1'b0;
      pl_we   = 1'b1;
      @(negedge clk);
    end
    pl_we = 1'b0;
    check_eq("rst_ack", 32'(bus.o_ack), 32'd0);
    check_eq("rst_rdata", 32'(bus.o_rdata), 32'd0);
    check_eq("rst_mem_we", 32'(bus.o_mem_we), 32'd0);
    check_eq("rst_mem_wdata", 32'(bus.o_mem_wdata), 32'd0);
    check_eq("rst_vga_wall", 32'(bus.o_vga_is_wall), 32'd0);
    preload(5, 7, 1'b1);
    preload(1, 1, 1'b1);
    preload(3, 1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single read
    @(posedge clk); #1;
    wr0 = n_wr;
    t0  = cyc;
    set_client(0, 1'b0, 5, 7, 1'b0);
    push_exp(0, 1'b0, 5, 7);
    wait_acks(1, 1'b0);
    check_eq("rd_latency", 32'(ack_cyc[0] - t0), 32'd3);
    check_eq("rd_no_write", 32'(n_wr), 32'(wr0));

    // Round-robin from pointer 0
    do_reset();
    @(posedge clk); #1;
    t0 = cyc;
    set_client(0, 1'b0, 1, 1, 1'b0);
    set_client(1, 1'b0, 2, 1, 1'b0);
    set_client(2, 1'b0, 3, 1, 1'b0);
    push_exp(0, 1'b0, 1, 1);
    push_exp(1, 1'b0, 2, 1);
    push_exp(2, 1'b0, 3, 1);
    push_exp(0, 1'b0, 1, 1);
    wait_acks(4, 1'b1);
    check_eq("rr_first_lat", 32'(ack_cyc[0] - t0), 32'd3);
    for (int i = 1; i < 4; i++) check_eq("rr_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);

    // VGA priority
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    bus.i_vga_busy = 1'b1;
    bus.i_vga_x    = 6'd6;
    bus.i_vga_y    = 6'd7;
    set_client(0, 1'b0, 1, 1, 1'b0);
    push_exp(0, 1'b0, 1, 1);
    ack0 = n_ack;
    @(posedge clk); #1;
    bus.i_vga_x = 6'd5;
    @(negedge clk);
    check_eq("vga_addr", 32'(bus.o_mem_addr), 32'(a(5, 7)));
    check_eq("vga_no_we", 32'(bus.o_mem_we), 32'd0);
    @(negedge clk);
    check_eq("vga_wall_old", 32'(bus.o_vga_is_wall), 32'd0);
    @(negedge clk);
    check_eq("vga_wall_new", 32'(bus.o_vga_is_wall), 32'd1);
    repeat (4) @(negedge clk);
    check_eq("vga_no_ack", 32'(n_ack), 32'(ack0));
    @(posedge clk); #1;
    bus.i_vga_busy = 1'b0;
    wait_acks(1, 1'b0);

    // Abort in ISSUE, then retry
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    wr0 = n_wr;
    set_client(1, 1'b1, 3, 3, 1'b1);
    push_exp(1, 1'b1, 3, 3);
    ack0 = n_ack;
    @(posedge clk); #1;
    bus.i_vga_busy = 1'b1;
    @(negedge clk);
    check_eq("abort_no_we", 32'(bus.o_mem_we), 32'd0);
    repeat (4) @(negedge clk);
    check_eq("abort_no_ack", 32'(n_ack), 32'(ack0));
    check_eq("abort_ram", 32'(ram[a(3, 3)]), 32'd0);
    @(posedge clk); #1;
    bus.i_vga_busy = 1'b0;
    wait_acks(1, 1'b0);
    @(negedge clk);
    check_eq("retry_ram", 32'(ram[a(3, 3)]), 32'd1);
    check_eq("retry_wr_cnt", 32'(n_wr), 32'(wr0 + 1));
`ifdef MAP_ARB_STATS_EN
    check_eq("abort_cnt", 32'(bus.o_abort_cnt), 32'd1);
`endif

    // Out-of-range read and write
    @(posedge clk); #1;
    wr0 = n_wr;
    set_client(2, 1'b0, 4, 44, 1'b0);
    push_exp(2, 1'b0, 4, 44);
    wait_acks(1, 1'b0);
    @(posedge clk); #1;
    set_client(2, 1'b1, 2, 50, 1'b1);
    push_exp(2, 1'b1, 2, 50);
    wait_acks(1, 1'b0);
    @(negedge clk);
    check_eq("oor_no_write", 32'(n_wr), 32'(wr0));
    check_eq("oor_ram", 32'(ram[a(2, 50)]), 32'd0);

    // Reset during CAPTURE
    @(posedge clk); #1;
    set_client(0, 1'b0, 5, 7, 1'b0);
    push_exp(0, 1'b0, 5, 7);
    wait_acks(1, 1'b0);
    @(posedge clk); #1;
    set_client(0, 1'b0, 1, 1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_ack", 32'(bus.o_ack), 32'd0);
    check_eq("midrst_rdata", 32'(bus.o_rdata), 32'd0);
    bus.i_req = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    t0 = cyc;
    set_client(0, 1'b0, 5, 7, 1'b0);
    set_client(1, 1'b0, 2, 1, 1'b0);
    push_exp(0, 1'b0, 5, 7);
    push_exp(1, 1'b0, 2, 1);
    wait_acks(2, 1'b0);
    check_eq("postrst_lat", 32'(ack_cyc[0] - t0), 32'd3);

    repeat (4) @(negedge clk);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/map_port_arbiter.md
Name: map_port_arbiter

Overview:
- Owns the single synchronous-read port of the wall-map RAM (64x44 grid, 1 bit per cell).
- Shares that port between the VGA renderer and N game-logic clients, such as tank collision checks and shell hit/wall-destroy writes.
- The VGA renderer has absolute priority while its busy flag is high.
- Clients are served round-robin during blanking, through a req/ack handshake.

Parameters:
- N_CLIENTS, 3, number of game-logic requesters.
- MAP_W, 64, grid columns; the address is {y,x} with x in 6 bits.
- MAP_H, 44, valid grid rows (game area only).
- COORD_W, 6, coordinate width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high; clears all state.
- i_vga_busy  in  1  renderer owns the map (active display lines).
- i_vga_x  in  COORD_W  renderer lookahead column.
- i_vga_y  in  COORD_W  renderer row.
- o_vga_is_wall  out  1  wall bit for the renderer; 2-cycle latency.
- i_req  in  N_CLIENTS  per-client request, level.
- i_we  in  N_CLIENTS  per-client write enable (1 = write, 0 = read).
- i_x  in  N_CLIENTS*COORD_W  packed client columns; client k uses slice [k*6+:6].
- i_y  in  N_CLIENTS*COORD_W  packed client rows.
- i_wdata  in  N_CLIENTS  per-client write bit.
- o_ack  out  N_CLIENTS  one-hot, 1-cycle completion pulse.
- o_rdata  out  1  read result; valid in the cycle o_ack pulses.
- o_mem_addr  out  12  RAM address.
- o_mem_we  out  1  RAM write strobe.
- o_mem_wdata  out  1  RAM write data.
- i_mem_rdata  in  1  RAM read data; valid 1 cycle after the address is presented.

Behaviour:
- Reset values: o_vga_is_wall=0, o_ack=0, o_rdata=0, o_mem_we=0, o_mem_wdata=0. RR pointer=0, state=IDLE.
- Memory-port mux:
  - When i_vga_busy=1, o_mem_addr={i_vga_y,i_vga_x} (combinational) and o_mem_we=0.
  - Otherwise o_mem_addr comes from the registered client address.
  - o_mem_we=1 only in ISSUE, for a valid write.
- VGA path: o_vga_is_wall <= i_mem_rdata every cycle. Coordinates presented at cycle N appear on o_vga_is_wall after edge N+2. No VGA range check is applied; y>=MAP_H reads whatever the RAM returns.
- FSM IDLE -> ISSUE -> CAPTURE -> IDLE.
- IDLE, with i_vga_busy=0 and |i_req:
  - Pick the winner = first requester at or after the RR pointer, wrapping at N_CLIENTS.
  - Register the winner's x, y, we, wdata and index; go to ISSUE.
  - With no request, or i_vga_busy=1, stay in IDLE.
- ISSUE:
  - If i_vga_busy=1: abort. No write is performed, no ack is given, return to IDLE. The client keeps req high and is re-arbitrated later; the RR pointer is unchanged.
  - Otherwise drive the address and write strobe, then go to CAPTURE.
- CAPTURE:
  - o_rdata <= i_mem_rdata (for a write, o_rdata <= 0).
  - o_ack[winner] pulses for 1 cycle; RR pointer <= winner+1 (mod N).
  - The VGA may take the port in this cycle; the capture still completes.
- Out-of-range access (y>=MAP_H): the RAM is not accessed. A read returns 1 (treated as wall), a write is dropped, and the ack is still given with the normal timing.
- Minimum client latency: req seen in IDLE -> ack 3 edges later. Back-to-back grants are possible: IDLE is re-entered with a new decision one cycle after the ack.
- Client rule: hold req and operands stable until ack; deassert req in the ack cycle or one cycle after it.
  - Operands are captured at grant; a req dropped after grant is still completed and acked.
  - Multiple simultaneous reqs: exactly one ack per transaction, never two acks in the same cycle.
- rst mid-transaction: the in-flight op is discarded. A write in ISSUE at the reset edge is not guaranteed to land.

Optional Feature:
- Macro MAP_ARB_STATS_EN.
- Defined: adds o_abort_cnt[15:0] (ISSUE aborts) and o_max_wait[15:0] (longest req-to-ack cycles seen by any client). Both are saturating and reset to 0.
- Undefined: these ports and the counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package map_pkg:
  - coord_t (6-bit) and map_addr_t (12-bit).
  - MAP_W, MAP_H, STATUS_BAR_HEIGHT.
  - arb_state_t enum {IDLE, ISSUE, CAPTURE}.
- Sub-module rr_arbiter: N-way round-robin grant from a req vector and a pointer; combinational, one-hot grant plus index.

Test Plan:
- Single read: busy=0; map(5,7)=1; client0 req read x=5,y=7 -> o_ack[0] pulses 3 cycles later with o_rdata=1, and the RAM sees no write.
- Round-robin: all 3 clients request continuously from pointer 0 -> acks in order 0,1,2,0, with 3 cycles between acks.
- Abort: busy rises in the ISSUE cycle of a client1 write of 1 to (3,3) -> no o_mem_we, no ack; map(3,3) stays 0. After busy falls the write retries and is acked; with stats enabled o_abort_cnt=1.
- VGA priority: busy=1 with client0 req high -> no ack; o_mem_addr={vga_y,vga_x}; o_vga_is_wall follows RAM contents 2 cycles later.
- Out-of-range: client2 reads y=44 -> ack with o_rdata=1 and no RAM access. A write to y=50 is acked and the RAM is unchanged.
- Reset: assert rst during CAPTURE -> o_ack=0, o_rdata=0, state IDLE immediately, pointer 0.
